tbtt_gen: RTL
=============

TBTT_GEN -- requirements
Module: tbtt_gen

Interface
REQ-001 Parameter TIMER_WIDTH, default 64: width of the TSF value and of next_tbtt.
REQ-002 Parameter BI_WIDTH, default 16: width of beacon_interval_tu, pre_tbtt_us and tbtt_count.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tsf_runtime_val  input  TIMER_WIDTH  current TSF in µs, from the TSF timer.
REQ-006 tsf_pulse_1M  input  1  one-cycle strobe, once per TSF µs.
REQ-007 tsf_load_control  input  1  TSF load control; a 1->0 transition means the TSF is being reloaded.
REQ-008 enable  input  1  level; 1 = generate TBTT events.
REQ-009 beacon_interval_tu  input  BI_WIDTH  beacon interval in TU (1 TU = 1024 µs); sampled at arm.
REQ-010 pre_tbtt_us  input  BI_WIDTH  lead time of the early warning in µs; sampled at arm.
REQ-011 tbtt_pulse  output  1  one-cycle pulse at each TBTT.
REQ-012 pre_tbtt_pulse  output  1  one-cycle pulse pre_tbtt_us before each TBTT.
REQ-013 next_tbtt  output  TIMER_WIDTH  absolute TSF of the upcoming TBTT; valid while armed=1.
REQ-014 tbtt_count  output  BI_WIDTH  number of TBTTs since the last arm; wraps modulo 2^BI_WIDTH.
REQ-015 armed  output  1  1 only in state RUN.

Function
REQ-016 States: IDLE, WAIT, CALC and RUN; outputs are registered.
REQ-017 Period P = beacon_interval_tu*1024, held in a BI_WIDTH+10-bit register.
REQ-018 IDLE->WAIT occurs when enable=1 and beacon_interval_tu!=0; the block stays in IDLE while beacon_interval_tu=0.
REQ-019 A TSF reload is the condition where tsf_load_control=0 and its one-cycle-delayed copy=1.
REQ-020 A TSF reload in WAIT, CALC or RUN forces WAIT on the next cycle, discarding all work in progress.
REQ-021 WAIT lasts exactly 1 cycle; at its end the block captures tsf_runtime_val into T, latches P and pre_tbtt_us, clears skip, then enters CALC.
REQ-022 CALC computes R = T mod P by bit-serial restoring division, one quotient bit per cycle, TIMER_WIDTH cycles exactly.
REQ-023 skip counts tsf_pulse_1M strobes seen during CALC; it is 8 bits and saturates at 255.
REQ-024 On leaving CALC: remaining = P - R - skip, next_tbtt = T - R + P, tbtt_count = 0, then the state goes to RUN.
REQ-025 If P - R <= skip, set remaining = P instead, emit tbtt_pulse on the first RUN cycle, and set next_tbtt = T - R + 2P.
REQ-026 In RUN, each tsf_pulse_1M decrements remaining.
REQ-027 When a decrement takes remaining from 1 to 0, that same cycle: tbtt_pulse=1, remaining reloads to P, next_tbtt += P, tbtt_count += 1.
REQ-028 pre_tbtt_pulse=1 in the cycle where a decrement makes remaining equal to pre_tbtt_us.
REQ-029 pre_tbtt_pulse is only generated when 0 < pre_tbtt_us < P.
REQ-030 Once latched, changes to beacon_interval_tu or pre_tbtt_us take effect only at the next arm (WAIT).
REQ-031 enable=0 in any state forces IDLE on the next cycle.
REQ-032 On entering IDLE, both pulses are 0, armed=0, and next_tbtt and tbtt_count hold their values.
REQ-033 Priority, highest first: rst, enable=0, TSF reload, normal operation.
REQ-034 The two pulses are never asserted outside RUN.
REQ-035 next_tbtt wraps modulo 2^TIMER_WIDTH.

Reset
REQ-036 rst=1 forces IDLE and zeroes tbtt_pulse, pre_tbtt_pulse, next_tbtt, tbtt_count, armed and all internal registers, including the delayed copy of tsf_load_control.
REQ-037 Reset applied mid-CALC or mid-RUN takes effect on the next edge; no pulse is emitted afterwards.

Verification
REQ-038 BI=100, pre=50, tsf=102300 at arm, no µs strobes during CALC -> armed 66 cycles after enable, next_tbtt=204800, pre_tbtt_pulse on the 50th strobe, tbtt_pulse on the 100th, tbtt_count=1.
REQ-039 Same setup with 2 µs strobes during CALC -> remaining=98 on entry to RUN, tbtt_pulse on the 98th RUN strobe.
REQ-040 TSF reload to 0 while in RUN -> WAIT, then recompute, next_tbtt=102400, tbtt_count=0, no stale pulse emitted.
REQ-041 BI=1, pre=0 -> tbtt_pulse every 1024 strobes, pre_tbtt_pulse never asserted, next_tbtt advancing by 1024.
REQ-042 tsf=102399 at arm with 1 strobe during CALC -> immediate tbtt_pulse on entry to RUN, next_tbtt=204800.
REQ-043 enable dropped mid-CALC, and separately rst mid-RUN -> IDLE and armed=0 next cycle; beacon_interval_tu=0 with enable=1 -> stays IDLE.

Source files
------------

// File: rtl/tbtt_gen.sv
// tbtt_gen: beacon TBTT and early-warning pulse generator slaved to the TSF.
// Arming finds the phase within the beacon period with a bit-serial divider.
module tbtt_gen #(
  parameter int TIMER_WIDTH = 64,
  parameter int BI_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
  input  logic                   tsf_pulse_1M,
  input  logic                   tsf_load_control,
  input  logic                   enable,
  input  logic [BI_WIDTH-1:0]    beacon_interval_tu,
  input  logic [BI_WIDTH-1:0]    pre_tbtt_us,
  output logic                   tbtt_pulse,
  output logic                   pre_tbtt_pulse,
  output logic [TIMER_WIDTH-1:0] next_tbtt,
  output logic [BI_WIDTH-1:0]    tbtt_count,
  output logic                   armed
);

  localparam int PW = BI_WIDTH + 10;
  localparam int CW = $clog2(TIMER_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CALC,
    RUN
  } state_t;

  state_t state;

  logic [PW-1:0]          period;
  logic [PW-1:0]          rem_q;
  logic [PW-1:0]          remaining;
  logic [BI_WIDTH-1:0]    pre_q;
  logic [TIMER_WIDTH-1:0] t_q;
  logic [TIMER_WIDTH-1:0] t_sh;
  logic [CW-1:0]          bit_cnt;
  logic [7:0]             skip;
  logic                   load_d;

  logic                   reload;
  logic [PW:0]            rem_sh;
  logic [PW:0]            rem_sub;
  logic [PW-1:0]          rem_nxt;
  logic [7:0]             skip_nxt;
  logic [PW-1:0]          gap;
  logic                   late;
  logic [PW-1:0]          rem_dec;
  logic                   pre_ok;
  logic [TIMER_WIDTH-1:0] base;

  always_comb begin
    reload   = load_d & ~tsf_load_control;
    rem_sh   = {rem_q, t_sh[TIMER_WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, period};
    // borrow out of the trial subtraction means restore
    rem_nxt  = rem_sub[PW] ? rem_sh[PW-1:0] : rem_sub[PW-1:0];
    skip_nxt = (tsf_pulse_1M && skip != 8'hff) ? skip + 8'd1 : skip;
    gap      = period - rem_nxt;
    late     = gap <= PW'(skip_nxt);
    rem_dec  = remaining - PW'(1);
    pre_ok   = (pre_q != '0) && (PW'(pre_q) < period);
    base     = t_q - TIMER_WIDTH'(rem_nxt) + TIMER_WIDTH'(period);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      load_d         <= 1'b0;
      tbtt_pulse     <= 1'b0;
      pre_tbtt_pulse <= 1'b0;
      next_tbtt      <= '0;
      tbtt_count     <= '0;
      armed          <= 1'b0;
      period         <= '0;
      rem_q          <= '0;
      remaining      <= '0;
      pre_q          <= '0;
      t_q            <= '0;
      t_sh           <= '0;
      bit_cnt        <= '0;
      skip           <= '0;
    end else begin
      load_d         <= tsf_load_control;
      tbtt_pulse     <= 1'b0;
      pre_tbtt_pulse <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        armed <= 1'b0;
      end else if (reload && state != IDLE) begin
        state <= WAIT;
        armed <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (beacon_interval_tu != '0)
              state <= WAIT;
          end
          WAIT: begin
            t_q     <= tsf_runtime_val;
            t_sh    <= tsf_runtime_val;
            period  <= {beacon_interval_tu, 10'b0};
            pre_q   <= pre_tbtt_us;
            skip    <= '0;
            rem_q   <= '0;
            bit_cnt <= '0;
            state   <= CALC;
          end
          CALC: begin
            rem_q   <= rem_nxt;
            t_sh    <= t_sh << 1;
            skip    <= skip_nxt;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(TIMER_WIDTH - 1)) begin
              tbtt_count <= '0;
              armed      <= 1'b1;
              state      <= RUN;
              // TBTT already passed while dividing: fire now
              if (late) begin
                remaining  <= period;
                next_tbtt  <= base + TIMER_WIDTH'(period);
                tbtt_pulse <= 1'b1;
              end else begin
                remaining  <= gap - PW'(skip_nxt);
                next_tbtt  <= base;
              end
            end
          end
          RUN: begin
            if (tsf_pulse_1M) begin
              if (remaining == PW'(1)) begin
                tbtt_pulse <= 1'b1;
                remaining  <= period;
                next_tbtt  <= next_tbtt + TIMER_WIDTH'(period);
                tbtt_count <= tbtt_count + BI_WIDTH'(1);
              end else begin
                remaining <= rem_dec;
                if (pre_ok && rem_dec == PW'(pre_q))
                  pre_tbtt_pulse <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
